// File: rtl/btn_event_sched_if.sv
// Event stream between the button scheduler and its consumer.
// Handshake: an event transfers on a rising clock edge where valid && ready; while valid is high and ready is low, id and code stay unchanged.
interface btn_event_sched_if #(
   parameter int ID_WIDTH = 2
);
   logic                valid;
   logic                ready;
   logic [ID_WIDTH-1:0] id;
   logic [1:0]          code;

   modport master (output valid, output id, output code, input ready);
   modport slave  (input valid, input id, input code, output ready);
endinterface

// File: rtl/btn_event_sched.sv
// Button bank scheduler: debounce CE prescaler, per-button press/release/long/repeat
// classification, one pending slot per button, round-robin arbitration onto one event stream.
module btn_event_sched #(
   parameter int N_BTN        = 4,
   parameter int ID_WIDTH     = 2,
   parameter int PRESC_DIV    = 50000,
   parameter int PRESC_WIDTH  = 16,
   parameter int TCNT_WIDTH   = 8,
   parameter int LONG_TICKS   = 100,
   parameter int REPEAT_TICKS = 20
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic                 en_i,
   input  logic [N_BTN-1:0]     btn_state_i,
   output logic                 tick_o,
   output logic [N_BTN-1:0]     ovf_o,
   input  logic                 ovf_clr_i,
   output logic [2*N_BTN-1:0]   dbg_state_o,
   btn_event_sched_if.master    ev
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PRESSED = 2'd1,
      ST_HELD    = 2'd2
   } btn_st_e;

   localparam logic [1:0] EV_PRESS   = 2'b00;
   localparam logic [1:0] EV_RELEASE = 2'b01;
   localparam logic [1:0] EV_LONG    = 2'b10;
   localparam logic [1:0] EV_REPEAT  = 2'b11;

   localparam logic [PRESC_WIDTH-1:0] PRESC_LAST = PRESC_WIDTH'(PRESC_DIV - 1);
   localparam logic [TCNT_WIDTH-1:0]  LONG_LAST  = TCNT_WIDTH'(LONG_TICKS - 1);
   localparam logic [TCNT_WIDTH-1:0]  REP_LAST   = TCNT_WIDTH'(REPEAT_TICKS - 1);
   localparam logic [ID_WIDTH:0]      N_EXT      = (ID_WIDTH + 1)'(N_BTN);

   // Prescaler
   logic [PRESC_WIDTH-1:0] presc_q, presc_d;
   logic                   tick_q, tick_d;
   logic                   timer_ce;

   // Edge detect
   logic [N_BTN-1:0] prev_q;
   logic [N_BTN-1:0] rise, fall;

   // Per-button classifier
   btn_st_e               st_q  [N_BTN];
   btn_st_e               st_d  [N_BTN];
   logic [TCNT_WIDTH-1:0] tmr_q [N_BTN];
   logic [TCNT_WIDTH-1:0] tmr_d [N_BTN];
   logic [N_BTN-1:0]      post;
   logic [1:0]            post_code [N_BTN];

   // Pending slots and overflow
   logic [N_BTN-1:0] slot_v_q, slot_v_d;
   logic [1:0]       slot_code_q [N_BTN];
   logic [1:0]       slot_code_d [N_BTN];
   logic [N_BTN-1:0] ovf_q, ovf_d, ovf_set;

   // Arbiter and output register
   logic [ID_WIDTH-1:0] ptr_q, ptr_d;
   logic                ev_valid_q, ev_valid_d;
   logic [ID_WIDTH-1:0] ev_id_q, ev_id_d;
   logic [1:0]          ev_code_q, ev_code_d;
   logic                load;
   logic                found;
   logic [ID_WIDTH-1:0] gnt_idx;
   logic [ID_WIDTH:0]   scan_sum;
   logic [ID_WIDTH-1:0] scan_idx;
   logic [ID_WIDTH:0]   nxt_sum;
   logic [N_BTN-1:0]    grant;

   always_comb begin
      presc_d = presc_q;
      tick_d  = 1'b0;
      if (en_i) begin
         if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            tick_d  = 1'b1;
         end else begin
            presc_d = presc_q + PRESC_WIDTH'(1);
         end
      end
   end

   // Gate with en_i too, so a tick already in flight when EN drops does not advance timers.
   assign timer_ce = tick_q & en_i;

   assign rise = btn_state_i & ~prev_q;
   assign fall = ~btn_state_i & prev_q;

   always_comb begin
      for (int i = 0; i < N_BTN; i++) begin
         st_d[i]      = st_q[i];
         tmr_d[i]     = tmr_q[i];
         post[i]      = 1'b0;
         post_code[i] = EV_PRESS;
         case (st_q[i])
            ST_IDLE: begin
               if (rise[i]) begin
                  st_d[i]      = ST_PRESSED;
                  tmr_d[i]     = '0;
                  post[i]      = 1'b1;
                  post_code[i] = EV_PRESS;
               end
            end
            ST_PRESSED: begin
               if (fall[i]) begin
                  st_d[i]      = ST_IDLE;
                  post[i]      = 1'b1;
                  post_code[i] = EV_RELEASE;
               end else if (timer_ce) begin
                  if (tmr_q[i] == LONG_LAST) begin
                     st_d[i]      = ST_HELD;
                     tmr_d[i]     = '0;
                     post[i]      = 1'b1;
                     post_code[i] = EV_LONG;
                  end else begin
                     tmr_d[i] = tmr_q[i] + TCNT_WIDTH'(1);
                  end
               end
            end
            ST_HELD: begin
               if (fall[i]) begin
                  st_d[i]      = ST_IDLE;
                  post[i]      = 1'b1;
                  post_code[i] = EV_RELEASE;
               end else if (timer_ce) begin
                  if (tmr_q[i] == REP_LAST) begin
                     tmr_d[i]     = '0;
                     post[i]      = 1'b1;
                     post_code[i] = EV_REPEAT;
                  end else begin
                     tmr_d[i] = tmr_q[i] + TCNT_WIDTH'(1);
                  end
               end
            end
            default: begin
               st_d[i]  = ST_IDLE;
               tmr_d[i] = '0;
            end
         endcase
      end
   end

   // A slot granted this cycle is free to take a new post without flagging overflow.
   always_comb begin
      slot_v_d = slot_v_q;
      ovf_set  = '0;
      for (int i = 0; i < N_BTN; i++) begin
         slot_code_d[i] = slot_code_q[i];
         if (post[i]) begin
            slot_v_d[i]    = 1'b1;
            slot_code_d[i] = post_code[i];
            ovf_set[i]     = slot_v_q[i] & ~grant[i];
         end else if (grant[i]) begin
            slot_v_d[i] = 1'b0;
         end
      end
      ovf_d = (ovf_q & ~{N_BTN{ovf_clr_i}}) | ovf_set;
   end

   always_comb begin
      load       = ~ev_valid_q | ev.ready;
      ev_valid_d = ev_valid_q;
      ev_id_d    = ev_id_q;
      ev_code_d  = ev_code_q;
      ptr_d      = ptr_q;
      grant      = '0;
      found      = 1'b0;
      gnt_idx    = ptr_q;
      scan_sum   = '0;
      scan_idx   = '0;
      for (int k = 0; k < N_BTN; k++) begin
         scan_sum = {1'b0, ptr_q} + (ID_WIDTH + 1)'(k);
         if (scan_sum >= N_EXT) scan_sum = scan_sum - N_EXT;
         scan_idx = scan_sum[ID_WIDTH-1:0];
         if (!found && slot_v_q[scan_idx]) begin
            found   = 1'b1;
            gnt_idx = scan_idx;
         end
      end
      nxt_sum = {1'b0, gnt_idx} + (ID_WIDTH + 1)'(1);
      if (nxt_sum >= N_EXT) nxt_sum = '0;
      if (load) begin
         if (found) begin
            ev_valid_d       = 1'b1;
            ev_id_d          = gnt_idx;
            ev_code_d        = slot_code_q[gnt_idx];
            grant[gnt_idx]   = 1'b1;
            ptr_d            = nxt_sum[ID_WIDTH-1:0];
         end else begin
            ev_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         presc_q    <= '0;
         tick_q     <= 1'b0;
         prev_q     <= '0;
         slot_v_q   <= '0;
         ovf_q      <= '0;
         ptr_q      <= '0;
         ev_valid_q <= 1'b0;
         ev_id_q    <= '0;
         ev_code_q  <= '0;
         for (int i = 0; i < N_BTN; i++) begin
            st_q[i]        <= ST_IDLE;
            tmr_q[i]       <= '0;
            slot_code_q[i] <= '0;
         end
      end else begin
         presc_q    <= presc_d;
         tick_q     <= tick_d;
         prev_q     <= btn_state_i;
         slot_v_q   <= slot_v_d;
         ovf_q      <= ovf_d;
         ptr_q      <= ptr_d;
         ev_valid_q <= ev_valid_d;
         ev_id_q    <= ev_id_d;
         ev_code_q  <= ev_code_d;
         for (int i = 0; i < N_BTN; i++) begin
            st_q[i]        <= st_d[i];
            tmr_q[i]       <= tmr_d[i];
            slot_code_q[i] <= slot_code_d[i];
         end
      end
   end

   for (genvar g = 0; g < N_BTN; g++) begin : g_dbg
      assign dbg_state_o[2*g +: 2] = st_q[g];
   end

   assign tick_o   = tick_q;
   assign ovf_o    = ovf_q;
   assign ev.valid = ev_valid_q;
   assign ev.id    = ev_id_q;
   assign ev.code  = ev_code_q;

endmodule

// File: tb/tb_btn_event_sched.sv
// Directed bench for btn_event_sched: cycle-exact checks plus an in-order event scoreboard.
module tb_btn_event_sched;

   localparam int N_BTN = 4;
   localparam int ID_WIDTH = 2;
   localparam logic [1:0] C_PRESS = 2'b00;
   localparam logic [1:0] C_REL   = 2'b01;
   localparam logic [1:0] C_LONG  = 2'b10;
   localparam logic [1:0] C_REP   = 2'b11;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             en = 1'b1;
   logic             ovf_clr = 1'b0;
   logic [N_BTN-1:0] btn = '0;
   logic             tick;
   logic [N_BTN-1:0] ovf;
   logic [2*N_BTN-1:0] dbg;

   int total = 0;
   int bad = 0;
   int cyc;
   logic [3:0] exp_q[$];

   btn_event_sched_if #(.ID_WIDTH(ID_WIDTH)) ev_bus ();

   btn_event_sched #(
      .N_BTN(N_BTN), .ID_WIDTH(ID_WIDTH), .PRESC_DIV(4), .PRESC_WIDTH(16),
      .TCNT_WIDTH(8), .LONG_TICKS(3), .REPEAT_TICKS(2)
   ) dut (
      .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .btn_state_i(btn),
      .tick_o(tick), .ovf_o(ovf), .ovf_clr_i(ovf_clr), .dbg_state_o(dbg),
      .ev(ev_bus)
   );

   // Clock / reset-relative cycle count
   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cyc %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Driver helpers: go() lands just after the edge that starts cycle c; at_neg() samples mid-cycle c.
   task automatic go(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic at_neg(input int c);
      go(c);
      @(negedge clk);
   endtask

   task automatic chk_ev(input string tag, input int c, input logic v,
                         input logic [1:0] id, input logic [1:0] code);
      at_neg(c);
      if (v) check(tag, {27'd0, ev_bus.valid, ev_bus.id, ev_bus.code}, {27'd0, 1'b1, id, code});
      else   check(tag, {31'd0, ev_bus.valid}, 32'd0);
   endtask

   task automatic push(input logic [1:0] id, input logic [1:0] code);
      exp_q.push_back({id, code});
   endtask

   // Scoreboard: every accepted event must match the head of the expected queue.
   always @(negedge clk) begin
      if (rst_n && ev_bus.valid && ev_bus.ready) begin
         if (exp_q.size() == 0) begin
            check("sb_unexpected", {28'd0, ev_bus.id, ev_bus.code}, 32'hFF);
         end else begin
            check("sb_event", {28'd0, ev_bus.id, ev_bus.code}, {28'd0, exp_q.pop_front()});
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: sim time exceeded at cyc %0d", cyc);
      $fatal(1);
   end

   initial begin
      int hold_bad;
      int idle_bad;
      int tick_bad;
      ev_bus.ready = 1'b1;

      #12;
      check("rst_valid", {31'd0, ev_bus.valid}, 32'd0);
      check("rst_tick", {31'd0, tick}, 32'd0);
      check("rst_ovf", {28'd0, ovf}, 32'd0);
      check("rst_idcode", {28'd0, ev_bus.id, ev_bus.code}, 32'd0);
      check("rst_fsm", {24'd0, dbg}, 32'd0);
      #5 rst_n = 1'b1;

      // Simultaneous rises on 0, 2, 3 with ptr at 0
      go(9);  btn = 4'b1101;
      push(0, C_PRESS); push(2, C_PRESS); push(3, C_PRESS);
      chk_ev("rr_none_yet", 10, 0, 0, 0);
      chk_ev("rr_first", 11, 1, 0, C_PRESS);
      chk_ev("rr_second", 12, 1, 2, C_PRESS);
      chk_ev("rr_third", 13, 1, 3, C_PRESS);
      chk_ev("rr_drain", 14, 0, 0, 0);
      go(14); btn = 4'b0000;
      push(0, C_REL); push(2, C_REL); push(3, C_REL);
      chk_ev("rr_rel0", 16, 1, 0, C_REL);
      chk_ev("rr_rel2", 17, 1, 2, C_REL);
      chk_ev("rr_rel3", 18, 1, 3, C_REL);
      go(20); btn = 4'b0001; push(0, C_PRESS);
      chk_ev("rr_lone0", 22, 1, 0, C_PRESS);
      check("rr_ovf", {28'd0, ovf}, 32'd0);
      go(24); btn = 4'b0000; push(0, C_REL);
      chk_ev("rr_lone0_rel", 26, 1, 0, C_REL);

      // Single press latency and one-cycle pulse
      go(39); btn = 4'b0010; push(1, C_PRESS);
      chk_ev("lat_t1", 40, 0, 0, 0);
      chk_ev("lat_t2", 41, 1, 1, C_PRESS);
      chk_ev("lat_t3", 42, 0, 0, 0);
      check("lat_ovf", {28'd0, ovf}, 32'd0);
      go(44); btn = 4'b0000; push(1, C_REL);
      chk_ev("lat_rel", 46, 1, 1, C_REL);

      // Long press, repeats, release on a timeout tick
      go(59); btn = 4'b0001;
      push(0, C_PRESS); push(0, C_LONG); push(0, C_REP); push(0, C_REP); push(0, C_REL);
      chk_ev("hold_press", 61, 1, 0, C_PRESS);
      chk_ev("hold_prelong", 69, 0, 0, 0);
      chk_ev("hold_long", 70, 1, 0, C_LONG);
      chk_ev("hold_prerep", 77, 0, 0, 0);
      chk_ev("hold_rep1", 78, 1, 0, C_REP);
      chk_ev("hold_rep2", 86, 1, 0, C_REP);
      at_neg(92);
      check("hold_tick", {31'd0, tick}, 32'd1);
      check("hold_fsm", {30'd0, dbg[1:0]}, 32'd2);
      go(92); btn = 4'b0000;
      chk_ev("hold_norep", 93, 0, 0, 0);
      chk_ev("hold_rel", 94, 1, 0, C_REL);
      chk_ev("hold_after", 95, 0, 0, 0);
      at_neg(96);
      check("hold_q_empty", exp_q.size(), 32'd0);

      // Backpressure and overflow
      go(100); ev_bus.ready = 1'b0; btn = 4'b0100;
      push(2, C_PRESS); push(1, C_REL); push(2, C_REL);
      hold_bad = 0;
      for (int c = 102; c <= 121; c++) begin
         at_neg(c);
         if (!(ev_bus.valid === 1'b1 && ev_bus.id === 2'd2 && ev_bus.code === C_PRESS)) hold_bad++;
         if (c == 104) btn = 4'b0110;
         if (c == 106) btn = 4'b0100;
         if (c == 108) btn = 4'b0000;
         if (c == 110) check("bp_ovf", {28'd0, ovf}, 32'h2);
      end
      check("bp_stable", hold_bad, 32'd0);
      go(122); ev_bus.ready = 1'b1;
      chk_ev("bp_first", 122, 1, 2, C_PRESS);
      chk_ev("bp_second", 123, 1, 1, C_REL);
      chk_ev("bp_third", 124, 1, 2, C_REL);
      chk_ev("bp_empty", 125, 0, 0, 0);
      at_neg(126);
      check("ovf_sticky", {28'd0, ovf}, 32'h2);
      go(127); ovf_clr = 1'b1;
      go(128); ovf_clr = 1'b0;
      at_neg(128);
      check("ovf_cleared", {28'd0, ovf}, 32'd0);

      // Async reset while HELD with an event stalled
      go(130); btn = 4'b0001; push(0, C_PRESS); push(0, C_LONG);
      chk_ev("ar_press", 132, 1, 0, C_PRESS);
      chk_ev("ar_prelong", 141, 0, 0, 0);
      chk_ev("ar_long", 142, 1, 0, C_LONG);
      go(143); ev_bus.ready = 1'b0;
      go(144); btn = 4'b1001;
      go(146); btn = 4'b0001;
      go(148); btn = 4'b1001;
      chk_ev("ar_stalled", 150, 1, 3, C_PRESS);
      check("ar_ovf_pre", {28'd0, ovf}, 32'h8);
      check("ar_q_empty", exp_q.size(), 32'd0);
      go(152);
      check("ar_tick_pre", {31'd0, tick}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("ar_valid", {31'd0, ev_bus.valid}, 32'd0);
      check("ar_tick", {31'd0, tick}, 32'd0);
      check("ar_ovf", {28'd0, ovf}, 32'd0);
      check("ar_idcode", {28'd0, ev_bus.id, ev_bus.code}, 32'd0);
      btn = 4'b0001;
      ev_bus.ready = 1'b1;
      #10 rst_n = 1'b1;
      push(0, C_PRESS); push(0, C_LONG);
      chk_ev("ar_post_t1", 1, 0, 0, 0);
      chk_ev("ar_post_press", 2, 1, 0, C_PRESS);
      idle_bad = 0;
      for (int c = 3; c <= 13; c++) begin
         at_neg(c);
         if (ev_bus.valid !== 1'b0) idle_bad++;
      end
      check("ar_no_early_long", idle_bad, 32'd0);
      chk_ev("ar_long_after", 14, 1, 0, C_LONG);

      // EN=0 freezes tick and hold timer
      go(15); btn = 4'b0000; push(0, C_REL);
      chk_ev("en_rel", 17, 1, 0, C_REL);
      go(21); en = 1'b0;
      go(22); btn = 4'b0001; push(0, C_PRESS);
      tick_bad = 0;
      for (int c = 22; c <= 121; c++) begin
         at_neg(c);
         if (tick !== 1'b0) tick_bad++;
         if (c == 24) check("en_press", {28'd0, ev_bus.valid, ev_bus.id, ev_bus.code}, {28'd0, 1'b1, 2'd0, C_PRESS});
      end
      check("en_tick_frozen", tick_bad, 32'd0);
      check("en_only_press", exp_q.size(), 32'd0);
      check("en_fsm", {30'd0, dbg[1:0]}, 32'd1);
      go(122); en = 1'b1; push(0, C_LONG);
      at_neg(124);
      check("en_tick_low", {31'd0, tick}, 32'd0);
      at_neg(125);
      check("en_tick_resume", {31'd0, tick}, 32'd1);
      chk_ev("en_prelong", 134, 0, 0, 0);
      chk_ev("en_long", 135, 1, 0, C_LONG);
      go(136); btn = 4'b0000; push(0, C_REL);
      chk_ev("en_final_rel", 138, 1, 0, C_REL);
      at_neg(142);
      check("final_q_empty", exp_q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/btn_event_sched.md
Name: btn_event_sched

Overview:
Scheduler and controller for a bank of N debounced buttons.
- Generates the shared CE tick that clocks all debouncer counters.
- Classifies each button's filtered level into PRESS / RELEASE / LONG / REPEAT events.
- Arbitrates those events round-robin onto a single valid/ready event stream for the downstream consumer (menu FSM, UART reporter).

Parameters:
N_BTN, 4, number of buttons (2..16)
ID_WIDTH, 2, width of EV_ID; must satisfy 2^ID_WIDTH >= N_BTN
PRESC_DIV, 50000, CLK cycles per TICK (>= 2)
PRESC_WIDTH, 16, prescaler counter width; PRESC_DIV <= 2^PRESC_WIDTH
TCNT_WIDTH, 8, per-button hold timer width
LONG_TICKS, 100, ticks of continuous press before LONG (1..2^TCNT_WIDTH-1)
REPEAT_TICKS, 20, ticks between REPEAT events after LONG (1..2^TCNT_WIDTH-1)

Ports:
CLK  in  1  system clock, all logic on rising edge
RST_N  in  1  asynchronous reset, active low
EN  in  1  prescaler enable; 0 freezes TICK and all hold timers
BTN_STATE  in  N_BTN  debounced button levels, 1 = pressed
TICK  out  1  one-CLK pulse every PRESC_DIV cycles; CE for debouncers
EV_VALID  out  1  event available
EV_READY  in  1  consumer accepts event when EV_VALID && EV_READY
EV_ID  out  ID_WIDTH  button index of current event
EV_CODE  out  2  00 PRESS, 01 RELEASE, 10 LONG, 11 REPEAT
OVF  out  N_BTN  sticky per-button overflow flags
OVF_CLR  in  1  clears all OVF bits (synchronous)

Behaviour:
- Reset (RST_N=0, async): TICK=0, EV_VALID=0, EV_ID=0, EV_CODE=0, OVF=0, prescaler=0, RR pointer=0, all button FSMs IDLE, timers=0, pending slots empty, prev-level regs=0.
- Prescaler: counts 0..PRESC_DIV-1 while EN=1, wraps to 0. TICK=1 (registered) in the cycle after the count equals PRESC_DIV-1. With EN=0, count holds and TICK=0.
- Edge detect: prev[i] <= BTN_STATE[i]. Rise = BTN_STATE & ~prev; fall = ~BTN_STATE & prev.
- Per-button FSM states: IDLE, PRESSED, HELD.
  - IDLE: on rise -> PRESSED, timer=0, post PRESS.
  - PRESSED: on fall -> IDLE, post RELEASE. Else on TICK: if timer==LONG_TICKS-1 -> HELD, timer=0, post LONG; otherwise timer+1.
  - HELD: on fall -> IDLE, post RELEASE. Else on TICK: if timer==REPEAT_TICKS-1 -> timer=0, post REPEAT; otherwise timer+1.
  - A fall in the same cycle as a timeout TICK: RELEASE only, no LONG/REPEAT.
  - Timers never wrap. EN=0 freezes them; press and release are still processed.
- Pending slot: one code register plus a valid bit per button.
  - Posting into an empty slot, or into a slot being granted in the same cycle, fills it; OVF is not set.
  - Posting into an occupied, non-granted slot overwrites the code with the newest event and sets OVF[i].
  - OVF_CLR clears OVF. A simultaneous set wins over the clear.
- Output register and arbiter:
  - Loads when EV_VALID==0 or (EV_VALID && EV_READY).
  - Selects the first pending index at or after ptr, searching cyclically. Loads EV_ID/EV_CODE, sets EV_VALID=1, clears that slot, ptr <= granted+1 mod N_BTN.
  - If nothing is pending, EV_VALID <= 0.
  - While EV_VALID && !EV_READY, EV_ID and EV_CODE are held stable.
  - Throughput: 1 event/cycle.
- Latency: BTN_STATE edge sampled at cycle t -> slot filled at t+1 -> EV_VALID=1 at t+2 if the output register is free.
- Reset release with a button already held: prev=0, so a PRESS is generated for it. This is intended.

Test Plan:
(Settings: N_BTN=4, PRESC_DIV=4, LONG_TICKS=3, REPEAT_TICKS=2, EN=1, EV_READY=1 unless stated.)
1. BTN_STATE[1] 0->1 sampled cycle 10 -> EV_VALID=1 for exactly cycle 12 with EV_ID=1, EV_CODE=00; OVF=0.
2. Hold BTN_STATE[0] high -> PRESS, then LONG on the 3rd TICK after press, then REPEAT every 2 TICKs (8 CLK apart). Drop it -> RELEASE. Drop it on a timeout TICK -> RELEASE only.
3. Buttons 0, 2, 3 rise in the same cycle -> events ID 0, 2, 3 on three consecutive cycles, all code 00. Next lone rise of button 0 with ptr=0 -> ID 0.
4. EV_READY=0, button 2 PRESS shown -> EV_ID/EV_CODE stable for 20 cycles. Meanwhile button 1 press then release -> OVF=4'b0010, pending code 01. EV_READY=1 -> ID 2 code 00, then ID 1 code 01. Then OVF_CLR -> OVF=0.
5. Assert RST_N=0 mid-HELD with EV_VALID=1 -> EV_VALID, TICK, OVF go to 0 immediately (no clock). Release reset with the button still high -> exactly one PRESS, no LONG for 3 TICKs.
6. EN=0, button held for 100 cycles -> TICK stays 0, only PRESS emitted. Set EN=1 -> LONG after 3 further TICKs.
